// File: rtl/nmea_stream_arbiter.sv
// Sentence-atomic arbiter. Two UART byte streams share one NMEA parser input.
// A source owns the parser from '$' to LF. The other source's '$' bytes are counted as drops.
module nmea_stream_arbiter #(
  parameter int MAX_LEN = 82
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx0_ready,
  input  logic [7:0] rx0_data,
  input  logic       rx1_ready,
  input  logic [7:0] rx1_data,
  output logic [7:0] data_out,
  output logic       data_out_ready,
  output logic       grant_id,
  output logic       busy,
  output logic       sentence_abort,
  output logic [7:0] drop_cnt0,
  output logic [7:0] drop_cnt1
);

  localparam logic [7:0] SOF     = 8'h24;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] MAX_CNT = 8'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, PASS0, PASS1} state_e;

  state_e     state_q;
  logic       pri_q, grant_q, busy_q, valid_q, abort_q;
  logic [7:0] dout_q, cnt_q, drop0_q, drop1_q;
  logic [7:0] drop0_d, drop1_d, cnt_d;

  logic       sof0, sof1, idle_pick, g_ready;
  logic [7:0] g_data;

  assign sof0      = rx0_ready && (rx0_data == SOF);
  assign sof1      = rx1_ready && (rx1_data == SOF);
  // On a simultaneous '$' the round-robin bit decides. Otherwise the lone '$' wins.
  assign idle_pick = (sof0 && sof1) ? pri_q : sof1;
  assign g_ready   = grant_q ? rx1_ready : rx0_ready;
  assign g_data    = grant_q ? rx1_data  : rx0_data;
  assign cnt_d     = cnt_q + 8'd1;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    drop0_d = drop0_q;
    drop1_d = drop1_q;
    unique case (state_q)
      IDLE: begin
        if (sof0 && sof1 && pri_q  && drop0_q != 8'hFF) drop0_d = drop0_q + 8'd1;
        if (sof0 && sof1 && !pri_q && drop1_q != 8'hFF) drop1_d = drop1_q + 8'd1;
      end
      PASS0: if (sof1 && drop1_q != 8'hFF) drop1_d = drop1_q + 8'd1;
      PASS1: if (sof0 && drop0_q != 8'hFF) drop0_d = drop0_q + 8'd1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      pri_q   <= 1'b0;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      dout_q  <= 8'h00;
      cnt_q   <= 8'h00;
      drop0_q <= 8'h00;
      drop1_q <= 8'h00;
    end else begin
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      dout_q  <= 8'h00;
      drop0_q <= drop0_d;
      drop1_q <= drop1_d;
      unique case (state_q)
        IDLE: begin
          if (sof0 || sof1) begin
            dout_q  <= SOF;
            valid_q <= 1'b1;
            cnt_q   <= 8'd1;
            grant_q <= idle_pick;
            busy_q  <= 1'b1;
            state_q <= idle_pick ? PASS1 : PASS0;
          end
        end
        PASS0, PASS1: begin
          if (g_ready) begin
            dout_q  <= g_data;
            valid_q <= 1'b1;
            if (g_data == LF) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              pri_q   <= ~grant_q;
            end else if (g_data == SOF) begin
              cnt_q <= 8'd1;
            end else if (cnt_d == MAX_CNT) begin
              abort_q <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              pri_q   <= ~grant_q;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out       = dout_q;
  assign data_out_ready = valid_q;
  assign grant_id       = grant_q;
  assign busy           = busy_q;
  assign sentence_abort = abort_q;
  assign drop_cnt0      = drop0_q;
  assign drop_cnt1      = drop1_q;

endmodule

// File: tb/tb_nmea_stream_arbiter.sv
// Bench for nmea_stream_arbiter. Two instances are checked every cycle against a sentence-level model:
// one with the default MAX_LEN and one with MAX_LEN=8.
module tb_nmea_stream_arbiter;

  localparam int LONG  = 82;
  localparam int SHORT = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       rx0_ready, rx1_ready;
  logic [7:0] rx0_data, rx1_data;

  logic [7:0] l_data, l_drop0, l_drop1, s_data, s_drop0, s_drop1;
  logic       l_rdy, l_gid, l_busy, l_abort, s_rdy, s_gid, s_busy, s_abort;

  always #5 CLK = ~CLK;

  nmea_stream_arbiter #(.MAX_LEN(LONG)) dut_long (
    .CLK(CLK), .RST(RST),
    .rx0_ready(rx0_ready), .rx0_data(rx0_data),
    .rx1_ready(rx1_ready), .rx1_data(rx1_data),
    .data_out(l_data), .data_out_ready(l_rdy), .grant_id(l_gid), .busy(l_busy),
    .sentence_abort(l_abort), .drop_cnt0(l_drop0), .drop_cnt1(l_drop1)
  );

  nmea_stream_arbiter #(.MAX_LEN(SHORT)) dut_short (
    .CLK(CLK), .RST(RST),
    .rx0_ready(rx0_ready), .rx0_data(rx0_data),
    .rx1_ready(rx1_ready), .rx1_data(rx1_data),
    .data_out(s_data), .data_out_ready(s_rdy), .grant_id(s_gid), .busy(s_busy),
    .sentence_abort(s_abort), .drop_cnt0(s_drop0), .drop_cnt1(s_drop1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: owner is -1 when no sentence is in progress.
  int m_max[2] = '{LONG, SHORT};
  int m_owner[2], m_len[2], m_pri[2], m_gid[2], m_drop[2][2];
  int e_data[2], e_rdy[2], e_abort[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1; m_len[m] = 0; m_pri[m] = 0; m_gid[m] = 0;
      m_drop[m][0] = 0; m_drop[m][1] = 0;
      e_data[m] = 0; e_rdy[m] = 0; e_abort[m] = 0;
    end
  endtask

  task automatic bump_drop(input int m, input int src);
    if (m_drop[m][src] < 255) m_drop[m][src]++;
  endtask

  task automatic model_step(input int m, input logic r0, input logic [7:0] d0,
                            input logic r1, input logic [7:0] d1);
    bit sof[2];
    bit rr[2];
    int dd[2];
    int k;
    rr[0] = r0; rr[1] = r1; dd[0] = d0; dd[1] = d1;
    sof[0] = r0 && d0 == 8'h24;
    sof[1] = r1 && d1 == 8'h24;
    e_data[m] = 0; e_rdy[m] = 0; e_abort[m] = 0;
    if (m_owner[m] < 0) begin
      k = -1;
      if (sof[0] && sof[1]) begin
        k = m_pri[m];
        bump_drop(m, 1 - k);
      end else if (sof[0]) k = 0;
      else if (sof[1]) k = 1;
      if (k >= 0) begin
        m_owner[m] = k; m_gid[m] = k; m_len[m] = 1;
        e_data[m] = 8'h24; e_rdy[m] = 1;
      end
    end else begin
      k = m_owner[m];
      if (sof[1 - k]) bump_drop(m, 1 - k);
      if (rr[k]) begin
        e_data[m] = dd[k]; e_rdy[m] = 1;
        if (dd[k] == 8'h0A) begin
          m_owner[m] = -1; m_pri[m] = 1 - k;
        end else if (dd[k] == 8'h24) begin
          m_len[m] = 1;
        end else begin
          m_len[m]++;
          if (m_len[m] >= m_max[m]) begin
            e_abort[m] = 1; m_owner[m] = -1; m_pri[m] = 1 - k;
          end
        end
      end
    end
  endtask

  task automatic check_dut(input string p, input int m, input logic [7:0] d, input logic r,
                           input logic g, input logic b, input logic a,
                           input logic [7:0] c0, input logic [7:0] c1);
    check({p, ".data_out"}, d, e_data[m]);
    check({p, ".ready"}, r, e_rdy[m]);
    check({p, ".grant_id"}, g, m_gid[m]);
    check({p, ".busy"}, b, (m_owner[m] >= 0) ? 1 : 0);
    check({p, ".abort"}, a, e_abort[m]);
    check({p, ".drop0"}, c0, m_drop[m][0]);
    check({p, ".drop1"}, c1, m_drop[m][1]);
  endtask

  task automatic check_all();
    check_dut("long", 0, l_data, l_rdy, l_gid, l_busy, l_abort, l_drop0, l_drop1);
    check_dut("short", 1, s_data, s_rdy, s_gid, s_busy, s_abort, s_drop0, s_drop1);
  endtask

  task automatic cycle(input logic r0, input logic [7:0] d0, input logic r1, input logic [7:0] d1);
    @(negedge CLK);
    rx0_ready = r0; rx0_data = d0; rx1_ready = r1; rx1_data = d1;
    model_step(0, r0, d0, r1, d1);
    model_step(1, r0, d0, r1, d1);
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic send0(input string s);
    for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i], 1'b0, 8'h00);
  endtask

  task automatic send1(input string s);
    for (int i = 0; i < s.len(); i++) cycle(1'b0, 8'h00, 1'b1, s[i]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".long_out"}, {l_data, l_rdy, l_gid, l_busy, l_abort, l_drop0, l_drop1}, 0);
    check({tag, ".short_out"}, {s_data, s_rdy, s_gid, s_busy, s_abort, s_drop0, s_drop1}, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rx0_ready = 1'b0; rx1_ready = 1'b0; rx0_data = 8'h00; rx1_data = 8'h00;
    #2 RST = 1'b1;
    #1 check_zero("async_rst");
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    int v;
    v = $urandom_range(0, 9);
    if (v < 2) return 8'h24;
    if (v == 2) return 8'h0A;
    return 8'($urandom_range(0, 255));
  endfunction

  logic [7:0] d0_before;

  initial begin
    RST = 1'b1;
    rx0_ready = 1'b0; rx1_ready = 1'b0; rx0_data = 8'h00; rx1_data = 8'h00;
    model_reset();
    #12 check_zero("reset");
    @(negedge CLK);
    RST = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 8'h00);

    // A complete GGA sentence from source 0. It is too long for the short instance, which aborts it.
    send0("$GPGGA,123519,4807.038,N,01131.000,E*47\n");
    check("gga.drop1", l_drop1, 0);

    // Simultaneous '$' from reset, then again after the LF, to exercise round-robin.
    do_reset();
    cycle(1'b1, 8'h24, 1'b1, 8'h24);
    check("tie1.gid", l_gid, 0);
    check("tie1.drop1", l_drop1, 1);
    send0("\n");
    cycle(1'b1, 8'h24, 1'b1, 8'h24);
    check("tie2.gid", l_gid, 1);
    check("tie2.drop0", l_drop0, 1);

    // Source 1 is granted. Source 0's '$' bytes and data must be discarded.
    d0_before = l_drop0;
    cycle(1'b1, 8'h24, 1'b1, "G");
    cycle(1'b1, "x",   1'b1, "P");
    cycle(1'b1, 8'h24, 1'b1, "G");
    cycle(1'b1, "y",   1'b1, "G");
    cycle(1'b1, 8'h24, 1'b1, "A");
    send1("\n");
    check("rej.drop0", l_drop0, d0_before + 8'd3);

    // The short instance cuts the sentence off at 8 bytes, with the abort pulse on 'G'.
    send0("$ABCDEFG");
    check("abort.pulse", s_abort, 1);
    check("abort.byte", s_data, "G");
    check("abort.busy", s_busy, 0);
    send0("HI");
    check("abort.drop_after", s_rdy, 0);
    send0("\n");
    cycle(1'b1, 8'h24, 1'b1, 8'h24);
    check("abort.pri", s_gid, 1);
    send1("\n");

    // Asynchronous reset mid-sentence. Stale source-0 bytes are ignored, and source 1 can then be granted.
    send0("$GPG");
    do_reset();
    send0("GA,1");
    check("rst.idle", l_busy, 0);
    send1("$");
    check("rst.gid", l_gid, 1);
    send1("GP\n");

    // Drop counter saturation.
    send0("$");
    for (int i = 0; i < 300; i++) cycle(1'b0, 8'h00, 1'b1, 8'h24);
    check("sat.long", l_drop1, 255);
    check("sat.short", s_drop1, 255);
    send0("\n");

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 1)), rand_byte(), 1'($urandom_range(0, 1)), rand_byte());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
